alu_share_arbiter: RTL and testbench

- Shares one combinational alu instance between two requesters, port 0 (main datapath) and port 1 (branch/address unit).
- Each port has a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; a registered operand stage feeds the ALU; each port has its own response register.
- Sits between the issue logic and the ALU in the processor datapath.

---
 rtl/alu_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the main datapath (port 0) and the branch/address unit (port 1).
// Round-robin request arbitration, a registered operand stage, and a held response register per port.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result0,
  output logic [WIDTH-1:0] rsp_result1,
  output logic [1:0]       rsp_zero,
  output logic [1:0]       rsp_err
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_NOR = OPW'(4);
  localparam logic [OPW-1:0] OP_SLT = OPW'(5);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } portState_e;

  portState_e       stateQ [2];
  portState_e       stateD [2];
  logic [1:0]       busy;
  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic             accept;
  logic             acceptId;
  logic             runQ;
  logic             rrQ;
  logic             opValidQ;
  logic             opIdQ;
  logic [WIDTH-1:0] opAQ;
  logic [WIDTH-1:0] opBQ;
  logic [OPW-1:0]   opCodeQ;
  logic [WIDTH-1:0] aluResult;
  logic             aluZero;
  logic             opIllegal;

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) stateQ[i] <= IDLE;
    end else begin
      for (int i = 0; i < 2; i++) stateQ[i] <= stateD[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stateD[i] = stateQ[i];
      case (stateQ[i])
        IDLE:    if (grant[i]) stateD[i] = PEND;
        PEND:    if (opValidQ && opIdQ == 1'(i)) stateD[i] = DONE;
        DONE:    if (rsp_ready[i]) stateD[i] = IDLE;
        default: stateD[i] = IDLE;
      endcase
      busy[i]      = (stateQ[i] != IDLE);
      rsp_valid[i] = (stateQ[i] == DONE);
    end
  end

  assign eligible = req_valid & ~busy;

  // runQ keeps grants off while reset is asserted and for the first edge after release.
  always_comb begin
    grant = 2'b00;
    if (runQ) begin
      case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rrQ ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign acceptId  = grant[1];

  always_comb begin
    // NOTE: default assigned first so no path leaves aluResult unassigned and infers a latch.
    aluResult = '0;
    case (opCodeQ)
      OP_ADD:  aluResult = opAQ + opBQ;
      OP_SUB:  aluResult = opAQ - opBQ;
      OP_AND:  aluResult = opAQ & opBQ;
      OP_OR:   aluResult = opAQ | opBQ;
      OP_NOR:  aluResult = ~(opAQ | opBQ);
      OP_SLT:  aluResult = WIDTH'($signed(opAQ) < $signed(opBQ));
      default: aluResult = '0;
    endcase
  end

  assign aluZero   = (aluResult == '0);
  assign opIllegal = (opCodeQ > OP_SLT);

  // NOTE: operand payload has no reset; opValidQ alone marks the stage empty, so these are plain data flops.
  always_ff @(posedge clk) begin
    if (accept) begin
      opAQ    <= acceptId ? req_a1 : req_a0;
      opBQ    <= acceptId ? req_b1 : req_b0;
      opCodeQ <= acceptId ? req_op1 : req_op0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      runQ        <= 1'b0;
      rrQ         <= 1'b0;
      opValidQ    <= 1'b0;
      opIdQ       <= 1'b0;
      rsp_result0 <= '0;
      rsp_result1 <= '0;
      rsp_zero    <= 2'b00;
      rsp_err     <= 2'b00;
    end else begin
      runQ     <= 1'b1;
      opValidQ <= accept;
      if (accept) begin
        opIdQ <= acceptId;
        rrQ   <= ~acceptId;
      end
      // A port's result register is only written for its own accepted op, so held responses stay stable.
      if (opValidQ) begin
        if (opIdQ) begin
          rsp_result1 <= opIllegal ? '0 : aluResult;
          rsp_zero[1] <= ~opIllegal & aluZero;
          rsp_err[1]  <= opIllegal;
        end else begin
          rsp_result0 <= opIllegal ? '0 : aluResult;
          rsp_zero[0] <= ~opIllegal & aluZero;
          rsp_err[0]  <= opIllegal;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: expected responses are queued per port at accept
// and compared when that port presents its response.
module tb_alu_share_arbiter;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [2:0]  req_op0 = '0, req_op1 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_result0, rsp_result1;
  logic [1:0]  rsp_zero, rsp_err;

  int   vectors = 0;
  int   miscompares = 0;
  rsp_t expQ0[$];
  rsp_t expQ1[$];

  alu_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result0(rsp_result0), .rsp_result1(rsp_result1),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int p, input rsp_t e);
    if (p == 0) expQ0.push_back(e);
    else        expQ1.push_back(e);
  endtask

  task automatic popCheck(input int p, input string tag);
    rsp_t e;
    int   pending;
    pending = (p == 0) ? expQ0.size() : expQ1.size();
    check({tag, "_pending"}, 32'(pending != 0), 32'd1);
    check({tag, "_valid"}, 32'(rsp_valid[p]), 32'd1);
    if (pending != 0) begin
      e = (p == 0) ? expQ0.pop_front() : expQ1.pop_front();
      check({tag, "_result"}, (p == 0) ? rsp_result0 : rsp_result1, e.result);
      check({tag, "_zero"}, 32'(rsp_zero[p]), 32'(e.zero));
      check({tag, "_err"}, 32'(rsp_err[p]), 32'(e.err));
    end
  endtask

  task automatic setReq(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (p == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
    else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
  endtask

  // Raises req_valid[p], waits (bounded) for the grant, queues the expectation, and leaves one cycle later.
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input rsp_t exp, input string tag);
    int n = 0;
    setReq(p, a, b, op);
    req_valid[p] = 1'b1;
    #1;
    while (!req_ready[p] && n < 20) begin tick(); n++; end
    check({tag, "_grant"}, 32'(req_ready[p]), 32'd1);
    push(p, exp);
    tick();
    req_valid[p] = 1'b0;
    #1;
  endtask

  task automatic waitRsp(input int p, input string tag);
    int n = 0;
    while (!rsp_valid[p] && n < 10) begin tick(); n++; end
    popCheck(p, tag);
    tick();
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    expQ0.delete();
    expQ1.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic holdCheck();
    check("bp_hold_valid", 32'(rsp_valid[1]), 32'd1);
    check("bp_hold_result", rsp_result1, 32'd4105);
    check("bp_hold_ready", 32'(req_ready[1]), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;

    // Reset state, with requests pending so req_ready gating is exercised.
    req_valid = 2'b11;
    setReq(0, 32'd9, 32'd9, 3'd0);
    setReq(1, 32'd9, 32'd9, 3'd0);
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_result0", rsp_result0, 32'd0);
    check("rst_result1", rsp_result1, 32'd0);
    check("rst_zero", 32'(rsp_zero), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    req_valid = 2'b00;
    reset_n = 1'b1;
    tick();
    tick();

    // Single op with fixed two-cycle latency; port 1 operands are junk while its valid is low.
    rsp_ready = 2'b11;
    setReq(1, 32'hDEAD_BEEF, 32'h1234_5678, 3'd7);
    setReq(0, 32'd125, 32'd360, 3'd0);
    req_valid = 2'b01;
    #1;
    check("single_ready", 32'(req_ready), 32'd1);
    push(0, rsp_t'{32'd485, 1'b0, 1'b0});
    tick();
    req_valid = 2'b00;
    #1;
    check("single_lat_n1", 32'(rsp_valid), 32'd0);
    tick();
    check("single_lat_n2", 32'(rsp_valid), 32'd1);
    popCheck(0, "single");
    tick();
    check("single_clear", 32'(rsp_valid), 32'd0);

    // Contention from reset: port 0 first, port 1 next cycle.
    doReset();
    rsp_ready = 2'b11;
    setReq(0, 32'd16, 32'd16, 3'd1);
    setReq(1, 32'(-56), 32'd56, 3'd5);
    req_valid = 2'b11;
    #1;
    check("cont_first", 32'(req_ready), 32'd1);
    push(0, rsp_t'{32'd0, 1'b1, 1'b0});
    tick();
    check("cont_second", 32'(req_ready), 32'd2);
    push(1, rsp_t'{32'd1, 1'b0, 1'b0});
    tick();
    req_valid = 2'b00;
    #1;
    popCheck(0, "cont_p0");
    tick();
    popCheck(1, "cont_p1");
    check("cont_p0_clear", 32'(rsp_valid[0]), 32'd0);
    tick();

    // After a lone port 0 grant the next tie goes to port 1, then port 0.
    issue(0, 32'd7, 32'd8, 3'd0, rsp_t'{32'd15, 1'b0, 1'b0}, "lone");
    waitRsp(0, "lone");
    setReq(0, 32'd16, 32'd16, 3'd1);
    setReq(1, 32'(-56), 32'd56, 3'd5);
    req_valid = 2'b11;
    #1;
    check("rep_first", 32'(req_ready), 32'd2);
    push(1, rsp_t'{32'd1, 1'b0, 1'b0});
    tick();
    check("rep_second", 32'(req_ready), 32'd1);
    push(0, rsp_t'{32'd0, 1'b1, 1'b0});
    tick();
    req_valid = 2'b00;
    #1;
    waitRsp(1, "rep_p1");
    waitRsp(0, "rep_p0");

    // Backpressure on port 1 while port 0 completes three adds.
    rsp_ready = 2'b01;
    issue(1, 32'd45897, 32'd612493, 3'd2, rsp_t'{32'd4105, 1'b0, 1'b0}, "bp");
    tick();
    setReq(1, 32'd1, 32'd1, 3'd0);
    req_valid[1] = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      a = 32'($urandom_range(1, 100000));
      b = 32'($urandom_range(1, 100000));
      setReq(0, a, b, 3'd0);
      req_valid[0] = 1'b1;
      #1;
      check("bp_add_grant", 32'(req_ready[0]), 32'd1);
      push(0, rsp_t'{a + b, 1'b0, 1'b0});
      holdCheck();
      tick();
      req_valid[0] = 1'b0;
      #1;
      holdCheck();
      tick();
      popCheck(0, "bp_add");
      holdCheck();
      tick();
    end
    rsp_ready = 2'b11;
    #1;
    popCheck(1, "bp");
    check("bp_same_cycle", 32'(req_ready[1]), 32'd0);
    tick();
    check("bp_next_grant", 32'(req_ready[1]), 32'd1);
    push(1, rsp_t'{32'd2, 1'b0, 1'b0});
    tick();
    req_valid = 2'b00;
    #1;
    waitRsp(1, "bp_next");

    // Illegal op codes, then a legal op clears the error flag.
    issue(1, 32'd123, 32'd456, 3'd7, rsp_t'{32'd0, 1'b0, 1'b1}, "ill7");
    waitRsp(1, "ill7");
    issue(0, 32'd0, 32'd0, 3'd6, rsp_t'{32'd0, 1'b0, 1'b1}, "ill6");
    waitRsp(0, "ill6");
    issue(1, 32'd4789, 32'd5236, 3'd4, rsp_t'{32'(-5878), 1'b0, 1'b0}, "nor");
    waitRsp(1, "nor");

    // Reset one cycle after an accept: everything clears at once, nothing resurfaces.
    issue(0, 32'd1000, 32'd2000, 3'd0, rsp_t'{32'd3000, 1'b0, 1'b0}, "rstmid");
    req_valid = 2'b10;
    reset_n = 1'b0;
    #1;
    check("rstmid_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd0);
    check("rstmid_result0", rsp_result0, 32'd0);
    check("rstmid_result1", rsp_result1, 32'd0);
    check("rstmid_zero", 32'(rsp_zero), 32'd0);
    check("rstmid_err", 32'(rsp_err), 32'd0);
    expQ0.delete();
    expQ1.delete();
    tick();
    req_valid = 2'b00;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rstmid_no_spurious", 32'(rsp_valid), 32'd0);
    end
    issue(0, 32'd5, 32'd3, 3'd1, rsp_t'{32'd2, 1'b0, 1'b0}, "post0");
    waitRsp(0, "post0");
    issue(1, 32'd10, 32'd3, 3'd5, rsp_t'{32'd0, 1'b1, 1'b0}, "post1");
    waitRsp(1, "post1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
